// File: rtl/mac_tx_arbiter_if.sv
// mac_tx_arbiter_if
// Bundles the frame-source side and the MAC TX byte path of the TX arbiter.
//   master : arbiter view (samples requests/bytes, drives grants and mac_tx_*)
//   slave  : environment view (frame sources and the TX framer)
// Signals:
//   src_req   [NUM_SRC]    per-source frame request, held until granted
//   src_grant [NUM_SRC]    one-hot grant
//   src_vld   [NUM_SRC]    byte valid per source
//   src_eop   [NUM_SRC]    last byte of frame, qualified by src_vld
//   src_dat   [8*NUM_SRC]  byte bus, source i at [8*i+7:8*i]
//   mac_tx_sop/eop/vld/dat forwarded byte stream into the framer
interface mac_tx_arbiter_if #(
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0]   src_req;
  logic [NUM_SRC-1:0]   src_grant;
  logic [NUM_SRC-1:0]   src_vld;
  logic [NUM_SRC-1:0]   src_eop;
  logic [8*NUM_SRC-1:0] src_dat;
  logic                 mac_tx_sop;
  logic                 mac_tx_eop;
  logic                 mac_tx_vld;
  logic [7:0]           mac_tx_dat;

  modport master (
    input  src_req, src_vld, src_eop, src_dat,
    output src_grant, mac_tx_sop, mac_tx_eop, mac_tx_vld, mac_tx_dat
  );

  modport slave (
    output src_req, src_vld, src_eop, src_dat,
    input  src_grant, mac_tx_sop, mac_tx_eop, mac_tx_vld, mac_tx_dat
  );
endinterface

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter
// Round-robin scheduler sharing the single MAC TX byte path between NUM_SRC
// frame sources. One whole frame is granted at a time and forwarded through
// one register stage; afterwards an inter-frame gap is held so the framer FIFO
// drains before the next grant. Frames longer than MAX_LEN are cut (eop forced,
// err_trunc pulsed) and the remainder of the source frame is discarded.
// Optional feature: define MAC_TX_PACE_EN to size the gap from the frame length
// (max(IFG_CYCLES, len*CLK_PER_BYTE + PACE_OVH), saturated at 0xFFFF); without
// it the gap is a fixed IFG_CYCLES.
// Ports:
//   sys_clk, sys_rst  clock, asynchronous active-high reset
//   bus               mac_tx_arbiter_if.master (sources in, grant + mac_tx out)
//   arb_busy          high whenever the arbiter is not idle
//   err_trunc         1-cycle pulse alongside the forced eop of a cut frame
//   frame_cnt         frames forwarded since reset, wraps
module mac_tx_arbiter #(
  parameter int NUM_SRC      = 3,
  parameter int IFG_CYCLES   = 96,
  parameter int MAX_LEN      = 1514,
  parameter int CLK_PER_BYTE = 8,
  parameter int PACE_OVH     = 560
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  mac_tx_arbiter_if.master  bus,
  output logic              arb_busy,
  output logic              err_trunc,
  output logic [15:0]       frame_cnt
);
  localparam int              IDX_W    = $clog2(NUM_SRC);
  localparam logic [IDX_W:0]  NSRC     = (IDX_W+1)'(NUM_SRC);
  localparam logic [IDX_W:0]  ONE      = (IDX_W+1)'(1);
  localparam logic [10:0]     LAST_IDX = 11'(MAX_LEN - 1);

  if (NUM_SRC < 2 || NUM_SRC > 8 || MAX_LEN < 1 || MAX_LEN > 2047 ||
      IFG_CYCLES < 0 || CLK_PER_BYTE < 1 || PACE_OVH < 0) begin : g_bad_param
    $error("mac_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;
  state_t state_q, state_d;

  logic [IDX_W-1:0]   rr_ptr, gnt_idx, pick_idx, next_ptr, off;
  logic [IDX_W:0]     sum, nsum;
  logic [NUM_SRC-1:0] req_rot, gnt_q;
  logic               pick_vld;
  logic [10:0]        byte_cnt;
  logic [15:0]        gap_cnt, gap_ld;
  logic               g_vld, g_eop;
  logic [7:0]         g_dat;
  logic               take, fwd, last, trunc, load_gap;
  logic               tx_vld_p1, tx_sop_p1, tx_eop_p1, trunc_p1;
  logic [7:0]         tx_dat_p1;

`ifdef MAC_TX_PACE_EN
  function automatic logic [15:0] gap_sat(input logic [10:0] len);
    logic [31:0] paced;
    paced = 32'(len) * 32'(CLK_PER_BYTE) + 32'(PACE_OVH);
    if (paced > 32'h0000_FFFF) paced = 32'h0000_FFFF;
    if (paced < 32'(IFG_CYCLES)) paced = 32'(IFG_CYCLES);
    return paced[15:0];
  endfunction
  // A cut frame occupied the wire for MAX_LEN bytes, whatever the source sent.
  assign gap_ld = gap_sat((state_q == DROP) ? 11'(MAX_LEN) : byte_cnt + 11'd1);
`else
  function automatic logic [15:0] gap_sat();
    return (IFG_CYCLES > 65535) ? 16'hFFFF : 16'(IFG_CYCLES);
  endfunction
  assign gap_ld = gap_sat();
`endif

  // Rotate requests so bit 0 is the current pointer; the lowest set bit wins.
  always_comb begin
    req_rot  = NUM_SRC'({bus.src_req, bus.src_req} >> rr_ptr);
    pick_vld = |req_rot;
    off      = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) off = IDX_W'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= NSRC) sum = sum - NSRC;
    pick_idx = sum[IDX_W-1:0];
    nsum = {1'b0, pick_idx} + ONE;
    if (nsum >= NSRC) nsum = '0;
    next_ptr = nsum[IDX_W-1:0];
  end

  assign g_vld = bus.src_vld[gnt_idx];
  assign g_eop = bus.src_eop[gnt_idx];
  assign g_dat = bus.src_dat[{gnt_idx, 3'b000} +: 8];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    fwd      = 1'b0;
    last     = 1'b0;
    trunc    = 1'b0;
    load_gap = 1'b0;
    case (state_q)
      IDLE: if (pick_vld) begin
        take    = 1'b1;
        state_d = XFER;
      end
      XFER: if (g_vld) begin
        fwd = 1'b1;
        if (g_eop) begin
          last     = 1'b1;
          load_gap = 1'b1;
          state_d  = GAP;
        end else if (byte_cnt == LAST_IDX) begin
          last    = 1'b1;
          trunc   = 1'b1;
          state_d = DROP;
        end
      end
      DROP: if (g_vld && g_eop) begin
        load_gap = 1'b1;
        state_d  = GAP;
      end
      GAP: if (gap_cnt <= 16'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered forward of the granted source's byte
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      gnt_q     <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      tx_vld_p1 <= 1'b0;
      tx_sop_p1 <= 1'b0;
      tx_eop_p1 <= 1'b0;
      tx_dat_p1 <= '0;
      trunc_p1  <= 1'b0;
    end else begin
      tx_vld_p1 <= fwd;
      tx_sop_p1 <= fwd && (byte_cnt == 11'd0);
      tx_eop_p1 <= last;
      tx_dat_p1 <= fwd ? g_dat : 8'h00;
      trunc_p1  <= trunc;
      if (take) begin
        gnt_q    <= {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_idx;
        gnt_idx  <= pick_idx;
        rr_ptr   <= next_ptr;
        byte_cnt <= '0;
      end
      if (fwd)  byte_cnt  <= byte_cnt + 11'd1;
      if (last) frame_cnt <= frame_cnt + 16'd1;
      // Grant is released only on the source's own eop, never on truncation.
      if (load_gap) begin
        gnt_q   <= '0;
        gap_cnt <= gap_ld;
      end else if (state_q == GAP) begin
        gap_cnt <= gap_cnt - 16'd1;
      end
    end
  end

  assign bus.src_grant  = gnt_q;
  assign bus.mac_tx_vld = tx_vld_p1;
  assign bus.mac_tx_sop = tx_sop_p1;
  assign bus.mac_tx_eop = tx_eop_p1;
  assign bus.mac_tx_dat = tx_dat_p1;
  assign err_trunc      = trunc_p1;
  assign arb_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mac_tx_arbiter.sv
module tb_mac_tx_arbiter;
  localparam int N    = 3;
  localparam int IFG  = 96;
  localparam int MAXL = 1514;
  localparam int CPB  = 8;
  localparam int OVH  = 560;
  localparam int WAIT_LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arb_busy, err_trunc;
  logic [15:0] frame_cnt;

  mac_tx_arbiter_if #(.NUM_SRC(N)) bus ();

  mac_tx_arbiter #(
    .NUM_SRC(N), .IFG_CYCLES(IFG), .MAX_LEN(MAXL), .CLK_PER_BYTE(CPB), .PACE_OVH(OVH)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .bus(bus),
    .arb_busy(arb_busy), .err_trunc(err_trunc), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    logic       sop;
    logic       eop;
    logic       trunc;
    int         fcnt;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         gnt_q[$];
  int         gap_q[$];
  logic [7:0] fixed_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_eop_cyc = 0;
  int         rr_ptr = 0;
  int         frames = 0;
  int         prev_gap = -1;
  bit         pending[N];
  bit         abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected cycles from the eop output cycle to the next grant, when a request is already waiting.
  function automatic int gap_for(input int len);
    int v;
    if (len > MAXL) return -1;
`ifdef MAC_TX_PACE_EN
    v = len * CPB + OVH;
    if (v > 65535) v = 65535;
    if (v < IFG) v = IFG;
`else
    v = IFG;
`endif
    return v + 1;
  endfunction

  // Round-robin rule: first pending source at or after the pointer, wrapping.
  function automatic int predict();
    for (int k = 0; k < N; k++) begin
      if (pending[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
    end
    return -1;
  endfunction

  // Non-granted sources chatter randomly; the arbiter must ignore them.
  task automatic rand_others(input int g);
    for (int i = 0; i < N; i++) begin
      if (i != g) begin
        bus.src_vld[i]         = 1'($urandom_range(0, 1));
        bus.src_eop[i]         = 1'($urandom_range(0, 1));
        bus.src_dat[8*i +: 8]  = 8'($urandom);
      end
    end
  endtask

  // Scoreboard monitor
  initial begin : monitor
    exp_t       me;
    int         eg, gd;
    logic [N-1:0] prev_gnt;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_gnt = '0;
      end else begin
        check("grant_onehot", 32'($countones(bus.src_grant) <= 1), 32'd1);
        if (bus.mac_tx_vld) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=no_byte", bus.mac_tx_dat);
          end else begin
            me = exp_q.pop_front();
            check("tx_dat", 32'(bus.mac_tx_dat), 32'(me.dat));
            check("tx_sop", 32'(bus.mac_tx_sop), 32'(me.sop));
            check("tx_eop", 32'(bus.mac_tx_eop), 32'(me.eop));
            check("err_trunc", 32'(err_trunc), 32'(me.trunc));
            check("tx_latency", 32'(cyc), 32'(me.cyc));
            if (me.eop) begin
              check("frame_cnt", 32'(frame_cnt), 32'(me.fcnt & 16'hFFFF));
              last_eop_cyc = cyc;
            end
          end
        end else begin
          check("idle_flags", 32'({bus.mac_tx_sop, bus.mac_tx_eop, err_trunc}), 32'd0);
        end
        if (prev_gnt == '0 && bus.src_grant != '0) begin
          if (gnt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant actual=%0b required=none", bus.src_grant);
          end else begin
            eg = gnt_q.pop_front();
            gd = gap_q.pop_front();
            check("grant_idx", 32'(bus.src_grant), 32'(1) << eg);
            if (gd >= 0) check("gap_cycles", 32'(cyc - last_eop_cyc), 32'(gd));
          end
        end
        prev_gnt = bus.src_grant;
      end
    end
  end

  task automatic check_all_zero();
    check("rst_vld",   32'(bus.mac_tx_vld), 32'd0);
    check("rst_sop",   32'(bus.mac_tx_sop), 32'd0);
    check("rst_eop",   32'(bus.mac_tx_eop), 32'd0);
    check("rst_dat",   32'(bus.mac_tx_dat), 32'd0);
    check("rst_grant", 32'(bus.src_grant),  32'd0);
    check("rst_busy",  32'(arb_busy),       32'd0);
    check("rst_trunc", 32'(err_trunc),      32'd0);
    check("rst_fcnt",  32'(frame_cnt),      32'd0);
  endtask

  // One granted frame of len bytes. gapmode: 0 none, 1 random vld gaps, 2 vld 1,0,0,1.
  // rst_at >= 0 asserts reset while byte rst_at is presented.
  task automatic do_frame(input int len, input int gapmode, input int rst_at, output int g);
    int eg, t, last_i;
    logic [7:0] b;
    bit lst;
    g = -1;
    if (abort) return;
    eg = predict();
    gnt_q.push_back(eg);
    gap_q.push_back(prev_gap);
    for (int i = 0; i < N; i++) bus.src_req[i] = pending[i];
    t = 0;
    while (bus.src_grant == '0 && t < WAIT_LIMIT) begin
      rand_others(-1);
      tick();
      t++;
    end
    if (bus.src_grant == '0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual=none required=src%0d", eg);
      abort = 1'b1;
      return;
    end
    for (int i = 0; i < N; i++) if (bus.src_grant[i]) g = i;
    rr_ptr = (eg + 1) % N;
    pending[g] = 1'b0;
    bus.src_req[g] = 1'b0;
    last_i = (len < MAXL) ? len - 1 : MAXL - 1;
    for (int i = 0; i < len; i++) begin
      if ((gapmode == 1 && $urandom_range(0, 3) == 0) || (gapmode == 2 && i == 2)) begin
        for (int k = 0; k < ((gapmode == 2) ? 2 : 1); k++) begin
          bus.src_vld[g] = 1'b0;
          bus.src_eop[g] = 1'($urandom_range(0, 1));
          bus.src_dat[8*g +: 8] = 8'($urandom);
          rand_others(g);
          tick();
        end
      end
      b = (fixed_q.size() > i) ? fixed_q[i] : 8'($urandom);
      if (len > MAXL && i == len - 1) check("grant_held_drop", 32'(bus.src_grant[g]), 32'd1);
      bus.src_vld[g] = 1'b1;
      bus.src_eop[g] = (i == len - 1);
      bus.src_dat[8*g +: 8] = b;
      rand_others(g);
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check_all_zero();
        exp_q.delete();
        gnt_q.delete();
        gap_q.delete();
        fixed_q.delete();
        for (int k = 0; k < N; k++) pending[k] = 1'b0;
        bus.src_req = '0;
        bus.src_vld = '0;
        bus.src_eop = '0;
        bus.src_dat = '0;
        rr_ptr = 0;
        frames = 0;
        prev_gap = -1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        return;
      end
      if (i <= last_i) begin
        lst = (i == last_i);
        if (lst) frames++;
        exp_q.push_back('{dat: b, sop: (i == 0), eop: lst, trunc: (lst && len > MAXL),
                          fcnt: (lst ? frames : 0), cyc: cyc + 1});
      end
      tick();
    end
    bus.src_vld[g] = 1'b0;
    bus.src_eop[g] = 1'b0;
    check("grant_drop", 32'(bus.src_grant), 32'd0);
    prev_gap = gap_for(len);
    fixed_q.delete();
  endtask

  initial begin : stim
    int g;
    bit any;
    bus.src_req = '0;
    bus.src_vld = '0;
    bus.src_eop = '0;
    bus.src_dat = '0;
    for (int k = 0; k < N; k++) pending[k] = 1'b0;
    repeat (3) tick();
    check_all_zero();
    rst = 1'b0;
    tick();

    // Single source, fixed payload.
    pending[1] = 1'b1;
    fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_frame(4, 0, -1, g);

    // All sources request continuously: strict rotation.
    for (int k = 0; k < N; k++) pending[k] = 1'b1;
    for (int r = 0; r < 6; r++) begin
      do_frame($urandom_range(1, 8), 0, -1, g);
      if (g >= 0) pending[g] = 1'b1;
    end

    // vld 1,0,0,1 mid-frame, then a 1-byte frame.
    do_frame(6, 2, -1, g);
    if (g >= 0) pending[g] = 1'b1;
    do_frame(1, 0, -1, g);
    if (g >= 0) pending[g] = 1'b1;

    // Random request sets, lengths and vld gaps.
    for (int r = 0; r < 12; r++) begin
      do_frame($urandom_range(1, 40), 1, -1, g);
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 2) == 0) pending[k] = 1'b1;
        any |= pending[k];
      end
      if (!any) pending[$urandom_range(0, N - 1)] = 1'b1;
    end

    // Oversized frame: cut at MAXL, remainder dropped.
    do_frame(MAXL + 6, 0, -1, g);
    pending[$urandom_range(0, N - 1)] = 1'b1;
    do_frame(60, 0, -1, g);

    // Reset while byte 3 is presented, then all request: source 0 first.
    pending[2] = 1'b1;
    do_frame(8, 0, 2, g);
    for (int k = 0; k < N; k++) pending[k] = 1'b1;
    do_frame(3, 0, -1, g);
    do_frame(5, 1, -1, g);

    repeat (5) tick();
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    check("grant_drain", 32'(gnt_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
